// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller for the 5-stage MIPS-lite pipeline.
// Tracks destinations of the instructions in EX, MEM and WB, detects RAW
// hazards against the instruction in ID, and drives the pipeline write
// enables, bubble and flush controls and the EX operand forwarding selects.
// It also sequences HALT: drain the pipe, then freeze it until reset.
module pipeline_hazard_controller #(
  parameter int REGADDR      = 5,
  parameter int CNTW         = 32,
  parameter int FORWARDING   = 1,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               idValid,
  input  logic [REGADDR-1:0] idRs,
  input  logic [REGADDR-1:0] idRt,
  input  logic               idUsesRs,
  input  logic               idUsesRt,
  input  logic [REGADDR-1:0] idDest,
  input  logic               idRegWrite,
  input  logic               idIsLoad,
  input  logic               idIsHalt,
  input  logic               exBranchTaken,
  output logic               pcWrite,
  output logic               ifidWrite,
  output logic               ifidFlush,
  output logic               idexBubble,
  output logic [1:0]         fwdSelA,
  output logic [1:0]         fwdSelB,
  output logic               halted,
  output logic [CNTW-1:0]    stallCount,
  output logic [CNTW-1:0]    flushCount
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;

  // Tracking slots: E = ID/EX, M = EX/MEM, W = MEM/WB
  logic                        e_valid_q, e_valid_d, e_rw_q, e_rw_d, e_load_q, e_load_d;
  logic [REGADDR-1:0]          e_dest_q, e_dest_d;
  logic [1:0][REGADDR-1:0]     e_src_q, e_src_d;
  logic [1:0]                  e_used_q, e_used_d;
  logic                        m_valid_q, m_valid_d, m_rw_q, m_rw_d;
  logic [REGADDR-1:0]          m_dest_q, m_dest_d;
  logic                        w_valid_q, w_valid_d, w_rw_q, w_rw_d;
  logic [REGADDR-1:0]          w_dest_q, w_dest_d;

  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic [1:0][REGADDR-1:0] id_src;
  logic [1:0]              id_used;
  logic [1:0]              hazard_src;
  logic [1:0][1:0]         fwd_sel;

  logic pc_write, ifid_write, ifid_flush, idex_bubble, halted_o;
  logic stall_inc, flush_inc;

  assign id_src  = {idRt, idRs};
  assign id_used = {idUsesRt, idUsesRs};

  // Per-source RAW detection (ID operands) and forwarding selection (EX operands); R0 never matches
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic match_e, match_m, fwd_m, fwd_w;
    assign match_e = e_valid_q & e_rw_q & (e_dest_q == id_src[gi]);
    assign match_m = m_valid_q & m_rw_q & (m_dest_q == id_src[gi]);
    assign hazard_src[gi] = idValid & id_used[gi] & (id_src[gi] != '0) &
                            ((FORWARDING != 0) ? (match_e & e_load_q) : (match_e | match_m));
    assign fwd_m = e_valid_q & e_used_q[gi] & m_valid_q & m_rw_q &
                   (m_dest_q != '0) & (m_dest_q == e_src_q[gi]);
    assign fwd_w = e_valid_q & e_used_q[gi] & w_valid_q & w_rw_q &
                   (w_dest_q != '0) & (w_dest_q == e_src_q[gi]);
    assign fwd_sel[gi] = (FORWARDING == 0) ? 2'b00 :
                         fwd_m ? 2'b01 : fwd_w ? 2'b10 : 2'b00;
  end

  // Sequencing FSM: pipeline controls and next state; a taken branch beats a stall
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted_o    = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (exBranchTaken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
        end else if (|hazard_src) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end else if (idValid && idIsHalt) begin
          state_d = ST_DRAIN;
          drain_d = DW'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        if (exBranchTaken) begin
          // An older branch ahead of HALT was taken: HALT is wrong-path
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
          state_d     = ST_RUN;
          drain_d     = '0;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (drain_q <= DW'(1)) begin
            state_d = ST_HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end
      ST_HALTED: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        halted_o    = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      halted_o    = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
    end
  end

  // Slot shift and saturating counter next values
  always_comb begin
    e_valid_d = idValid & ~idex_bubble;
    e_rw_d    = idRegWrite;
    e_load_d  = idIsLoad;
    e_dest_d  = idDest;
    e_src_d   = id_src;
    e_used_d  = id_used;
    m_valid_d = e_valid_q;
    m_rw_d    = e_rw_q;
    m_dest_d  = e_dest_q;
    w_valid_d = m_valid_q;
    w_rw_d    = m_rw_q;
    w_dest_d  = m_dest_q;
    stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNTW'(1) : stall_cnt_q;
    flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNTW'(1) : flush_cnt_q;
  end

  // State, slot and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      e_valid_q   <= 1'b0;
      e_rw_q      <= 1'b0;
      e_load_q    <= 1'b0;
      e_dest_q    <= '0;
      e_src_q     <= '0;
      e_used_q    <= '0;
      m_valid_q   <= 1'b0;
      m_rw_q      <= 1'b0;
      m_dest_q    <= '0;
      w_valid_q   <= 1'b0;
      w_rw_q      <= 1'b0;
      w_dest_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      e_valid_q   <= e_valid_d;
      e_rw_q      <= e_rw_d;
      e_load_q    <= e_load_d;
      e_dest_q    <= e_dest_d;
      e_src_q     <= e_src_d;
      e_used_q    <= e_used_d;
      m_valid_q   <= m_valid_d;
      m_rw_q      <= m_rw_d;
      m_dest_q    <= m_dest_d;
      w_valid_q   <= w_valid_d;
      w_rw_q      <= w_rw_d;
      w_dest_q    <= w_dest_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pcWrite    = pc_write;
  assign ifidWrite  = ifid_write;
  assign ifidFlush  = ifid_flush;
  assign idexBubble = idex_bubble;
  assign halted     = halted_o;
  assign fwdSelA    = reset ? fwd_sel[0] : 2'b00;
  assign fwdSelB    = reset ? fwd_sel[1] : 2'b00;
  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: a forwarding instance (32-bit
// counters) and a no-forwarding instance (2-bit counters) share stimulus.
// Expected control vectors are queued as each ID instruction is driven and
// popped at the falling edge to compare against the DUT.
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, idValid, idUsesRs, idUsesRt, idRegWrite, idIsLoad, idIsHalt, exBranchTaken;
  logic [4:0] idRs, idRt, idDest;

  logic        pcWrite, ifidWrite, ifidFlush, idexBubble, halted;
  logic [1:0]  fwdSelA, fwdSelB;
  logic [31:0] stallCount, flushCount;

  logic        pcWrite0, ifidWrite0, ifidFlush0, idexBubble0, halted0;
  logic [1:0]  fwdSelA0, fwdSelB0;
  logic [1:0]  stallCount0, flushCount0;

  pipeline_hazard_controller #(.REGADDR(5), .CNTW(32), .FORWARDING(1), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .idValid(idValid), .idRs(idRs), .idRt(idRt),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idDest(idDest), .idRegWrite(idRegWrite),
    .idIsLoad(idIsLoad), .idIsHalt(idIsHalt), .exBranchTaken(exBranchTaken),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush), .idexBubble(idexBubble),
    .fwdSelA(fwdSelA), .fwdSelB(fwdSelB), .halted(halted),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  pipeline_hazard_controller #(.REGADDR(5), .CNTW(2), .FORWARDING(0), .DRAIN_CYCLES(3)) dut0 (
    .clk(clk), .reset(reset), .idValid(idValid), .idRs(idRs), .idRt(idRt),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idDest(idDest), .idRegWrite(idRegWrite),
    .idIsLoad(idIsLoad), .idIsHalt(idIsHalt), .exBranchTaken(exBranchTaken),
    .pcWrite(pcWrite0), .ifidWrite(ifidWrite0), .ifidFlush(ifidFlush0), .idexBubble(idexBubble0),
    .fwdSelA(fwdSelA0), .fwdSelB(fwdSelB0), .halted(halted0),
    .stallCount(stallCount0), .flushCount(flushCount0)
  );

  typedef struct packed {
    logic v; logic [4:0] rs; logic [4:0] rt; logic urs; logic urt;
    logic [4:0] dst; logic rw; logic ld; logic hlt; logic br;
  } instr_t;

  typedef struct {
    string      name;
    logic [8:0] vec;
    logic [8:0] mask;
  } exp_t;

  // Vector layout: {pcWrite, ifidWrite, ifidFlush, idexBubble, fwdSelA, fwdSelB, halted}
  localparam logic [8:0] RUN00  = 9'b110000000;
  localparam logic [8:0] STALLV = 9'b000100000;
  localparam logic [8:0] HALTV  = 9'b000100001;
  localparam logic [8:0] RESETV = 9'b001100000;
  localparam logic [8:0] FLUSHV = 9'b101100000;
  localparam logic [8:0] ALL    = 9'b111111111;
  localparam logic [8:0] FMASK  = 9'b101111111;

  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic instr_t mk(input int v, input int rs, input int rt, input int urs,
                                input int urt, input int dst, input int rw, input int ld,
                                input int hlt, input int br);
    instr_t x;
    x.v = v[0]; x.rs = rs[4:0]; x.rt = rt[4:0]; x.urs = urs[0]; x.urt = urt[0];
    x.dst = dst[4:0]; x.rw = rw[0]; x.ld = ld[0]; x.hlt = hlt[0]; x.br = br[0];
    return x;
  endfunction

  function automatic logic [8:0] obs_vec(input bit which);
    if (which) return {pcWrite0, ifidWrite0, ifidFlush0, idexBubble0, fwdSelA0, fwdSelB0, halted0};
    return {pcWrite, ifidWrite, ifidFlush, idexBubble, fwdSelA, fwdSelB, halted};
  endfunction

  task automatic drive(input instr_t x);
    idValid = x.v; idRs = x.rs; idRt = x.rt; idUsesRs = x.urs; idUsesRt = x.urt;
    idDest = x.dst; idRegWrite = x.rw; idIsLoad = x.ld; idIsHalt = x.hlt; exBranchTaken = x.br;
  endtask

  task automatic push_exp(input string nm, input logic [8:0] v, input logic [8:0] m);
    exp_t ep;
    ep.name = nm; ep.vec = v; ep.mask = m;
    exp_q.push_back(ep);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    drive(mk(1,1,2,1,1,3,1,1,0,1));
    push_exp("reset_outputs", RESETV, ALL);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if (obs_vec(1'b0) !== e.vec) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, obs_vec(1'b0), e.vec);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (stallCount !== 32'd0 || flushCount !== 32'd0) begin
      n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stallCount, flushCount);
    end
    reset = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,0));
    push_exp("reset_release", RUN00, ALL);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if (obs_vec(1'b0) !== e.vec) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, obs_vec(1'b0), e.vec);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    instr_t s [4]; logic [8:0] x [4]; exp_t e;
    apply_reset();
    s[0] = mk(1,2,1,1,0,1,1,1,0,0); x[0] = RUN00;       // lw r1,0(r2)
    s[1] = mk(1,1,4,1,1,3,1,0,0,0); x[1] = STALLV;      // add r3,r1,r4
    s[2] = s[1];                    x[2] = RUN00;
    s[3] = mk(0,0,0,0,0,0,0,0,0,0); x[3] = 9'b110010000; // add in EX, fwdA=MEM/WB
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      push_exp($sformatf("load_use[%0d]", i), x[i], ALL);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs_vec(1'b0) !== e.vec) begin
        n_bad++; $display("FAIL %s: got %b want %b", e.name, obs_vec(1'b0), e.vec);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stallCount !== 32'd1) begin
      n_bad++; $display("FAIL load_use_stallcount: got %0d want 1", stallCount);
    end
  endtask

  task automatic test_fwd_ex();
    instr_t s [3]; logic [8:0] x [3]; exp_t e;
    apply_reset();
    s[0] = mk(1,2,3,1,1,1,1,0,0,0); x[0] = RUN00;        // add r1,r2,r3
    s[1] = mk(1,1,1,1,1,5,1,0,0,0); x[1] = RUN00;        // sub r5,r1,r1
    s[2] = mk(0,0,0,0,0,0,0,0,0,0); x[2] = 9'b110001010; // both from EX/MEM
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      push_exp($sformatf("fwd_ex[%0d]", i), x[i], ALL);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs_vec(1'b0) !== e.vec) begin
        n_bad++; $display("FAIL %s: got %b want %b", e.name, obs_vec(1'b0), e.vec);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stallCount !== 32'd0) begin
      n_bad++; $display("FAIL fwd_ex_stallcount: got %0d want 0", stallCount);
    end
  endtask

  task automatic test_m_over_w();
    instr_t s [4]; logic [8:0] x [4]; exp_t e;
    apply_reset();
    s[0] = mk(1,2,3,1,1,1,1,0,0,0); x[0] = RUN00;        // add r1,r2,r3
    s[1] = mk(1,4,5,1,1,1,1,0,0,0); x[1] = RUN00;        // add r1,r4,r5
    s[2] = mk(1,1,7,1,1,6,1,0,0,0); x[2] = RUN00;        // or r6,r1,r7
    s[3] = mk(0,0,0,0,0,0,0,0,0,0); x[3] = 9'b110001000; // fwdA=EX/MEM wins
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      push_exp($sformatf("m_over_w[%0d]", i), x[i], ALL);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs_vec(1'b0) !== e.vec) begin
        n_bad++; $display("FAIL %s: got %b want %b", e.name, obs_vec(1'b0), e.vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_r0();
    instr_t s [3]; logic [8:0] x [3]; exp_t e;
    apply_reset();
    s[0] = mk(1,2,0,1,0,0,1,1,0,0); x[0] = RUN00;  // lw r0,0(r2)
    s[1] = mk(1,0,0,1,1,3,1,0,0,0); x[1] = RUN00;  // add r3,r0,r0: no stall
    s[2] = mk(0,0,0,0,0,0,0,0,0,0); x[2] = RUN00;  // no forwarding of r0
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      push_exp($sformatf("r0[%0d]", i), x[i], ALL);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs_vec(1'b0) !== e.vec) begin
        n_bad++; $display("FAIL %s: got %b want %b", e.name, obs_vec(1'b0), e.vec);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stallCount !== 32'd0) begin
      n_bad++; $display("FAIL r0_stallcount: got %0d want 0", stallCount);
    end
  endtask

  task automatic test_flush_over_stall();
    instr_t s [3]; logic [8:0] x [3]; logic [8:0] m [3]; exp_t e;
    apply_reset();
    s[0] = mk(1,2,1,1,0,1,1,1,0,0); x[0] = RUN00;  m[0] = ALL;
    s[1] = mk(1,1,4,1,1,3,1,0,0,1); x[1] = FLUSHV; m[1] = FMASK; // load-use + taken branch
    s[2] = mk(0,0,0,0,0,0,0,0,0,0); x[2] = RUN00;  m[2] = ALL;
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      push_exp($sformatf("flush_over_stall[%0d]", i), x[i], m[i]);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ((obs_vec(1'b0) & e.mask) !== (e.vec & e.mask)) begin
        n_bad++; $display("FAIL %s: got %b want %b (mask %b)", e.name, obs_vec(1'b0), e.vec, e.mask);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (flushCount !== 32'd1 || stallCount !== 32'd0) begin
      n_bad++; $display("FAIL flush_over_stall_counts: got flush %0d stall %0d want 1/0", flushCount, stallCount);
    end
  endtask

  task automatic test_halt();
    instr_t s [7]; logic [8:0] x [7]; exp_t e;
    apply_reset();
    s[0] = mk(1,0,0,0,0,0,0,0,1,0); x[0] = RUN00;  // HALT in ID
    for (int i = 1; i < 7; i++) s[i] = mk(0,0,0,0,0,0,0,0,0,0);
    x[1] = STALLV; x[2] = STALLV; x[3] = STALLV;   // three drain cycles
    x[4] = HALTV;  x[5] = HALTV;  x[6] = HALTV;
    s[5] = mk(0,0,0,0,0,0,0,0,0,1);                // branch ignored once halted
    for (int i = 0; i < 7; i++) begin
      drive(s[i]);
      push_exp($sformatf("halt[%0d]", i), x[i], ALL);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs_vec(1'b0) !== e.vec) begin
        n_bad++; $display("FAIL %s: got %b want %b", e.name, obs_vec(1'b0), e.vec);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (flushCount !== 32'd0 || stallCount !== 32'd0) begin
      n_bad++; $display("FAIL halt_counts_frozen: got flush %0d stall %0d want 0/0", flushCount, stallCount);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,0));
    push_exp("halt_reset_to_run", RUN00, ALL);
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if (obs_vec(1'b0) !== e.vec) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, obs_vec(1'b0), e.vec);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_halt_cancel();
    instr_t s [5]; logic [8:0] x [5]; logic [8:0] m [5]; exp_t e;
    apply_reset();
    s[0] = mk(1,0,0,0,0,0,0,0,1,0); x[0] = RUN00;  m[0] = ALL;
    s[1] = mk(0,0,0,0,0,0,0,0,0,1); x[1] = FLUSHV; m[1] = FMASK; // branch as HALT enters E
    for (int i = 2; i < 5; i++) begin
      s[i] = mk(0,0,0,0,0,0,0,0,0,0); x[i] = RUN00; m[i] = ALL;
    end
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      push_exp($sformatf("halt_cancel[%0d]", i), x[i], m[i]);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ((obs_vec(1'b0) & e.mask) !== (e.vec & e.mask)) begin
        n_bad++; $display("FAIL %s: got %b want %b (mask %b)", e.name, obs_vec(1'b0), e.vec, e.mask);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (flushCount !== 32'd1) begin
      n_bad++; $display("FAIL halt_cancel_flushcount: got %0d want 1", flushCount);
    end
  endtask

  task automatic test_no_forwarding();
    instr_t s [8]; logic [8:0] x [8]; exp_t e;
    instr_t p, c;
    apply_reset();
    p = mk(1,6,7,1,1,1,1,0,0,0);   // add r1,r6,r7
    c = mk(1,1,5,1,1,2,1,0,0,0);   // add r2,r1,r5
    s[0] = p; x[0] = RUN00;
    s[1] = c; x[1] = STALLV;
    s[2] = c; x[2] = STALLV;
    s[3] = c; x[3] = RUN00;
    s[4] = p; x[4] = RUN00;
    s[5] = c; x[5] = STALLV;
    s[6] = c; x[6] = STALLV;
    s[7] = c; x[7] = RUN00;
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      push_exp($sformatf("no_fwd[%0d]", i), x[i], ALL);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs_vec(1'b1) !== e.vec) begin
        n_bad++; $display("FAIL %s: got %b want %b", e.name, obs_vec(1'b1), e.vec);
      end
      @(posedge clk); #1;
      if (i == 3) begin
        n_cmp++;
        if (stallCount0 !== 2'd2) begin
          n_bad++; $display("FAIL no_fwd_stallcount: got %0d want 2", stallCount0);
        end
      end
    end
    n_cmp++;
    if (stallCount0 !== 2'd3) begin
      n_bad++; $display("FAIL no_fwd_saturate: got %0d want 3", stallCount0);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_fwd_ex();
    test_m_over_w();
    test_r0();
    test_flush_over_stall();
    test_halt();
    test_halt_cancel();
    test_no_forwarding();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
